// File: rtl/div_reload_pkg.sv
// div_reload_pkg: nibble width and MODE encodings for the div_reload cell.
`default_nettype none

package div_reload_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    MODE_AUTO    = 1'b0,
    MODE_ONESHOT = 1'b1
  } mode_e;

endpackage

`default_nettype wire

// File: rtl/dcnt4.sv
// dcnt4: 4-bit synchronous loadable down-counter slice with borrow chain.
`default_nettype none

module dcnt4
  import div_reload_pkg::*;
(
  input  logic                CK,
  input  logic                nRESET,
  input  logic [NIBBLE_W-1:0] D,
  input  logic                nL,
  input  logic                DEC,
  input  logic                BI,
  output logic [NIBBLE_W-1:0] Q,
  output logic                BO
);

  logic [NIBBLE_W-1:0] q_q;
  logic [NIBBLE_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (!nL) begin
      q_d = D;
    end else if (DEC) begin
      q_d = q_q - {{(NIBBLE_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CK) begin
    if (!nRESET) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign BO = BI & (q_q == '0);

endmodule

`default_nettype wire

// File: rtl/div_reload.sv
// div_reload: cascaded down-counter divider with auto-reload / one-shot
// terminal handling, registered TC pulse and RUN arm flag.
`default_nettype none

module div_reload
  import div_reload_pkg::*;
#(
  parameter int STAGES = 4
) (
  input  logic                       CK,
  input  logic                       nRESET,
  input  logic [NIBBLE_W*STAGES-1:0] D,
  input  logic                       nL,
  input  logic                       EN,
  input  logic                       BI,
  input  logic                       MODE,
  output logic [NIBBLE_W*STAGES-1:0] Q,
  output logic                       BO,
  output logic                       TC,
  output logic                       RUN
);

  localparam int W = NIBBLE_W * STAGES;

  logic [W-1:0] q_w;
  logic         run_q, run_d;
  logic         tc_q, tc_d;
  logic         q_zero_w;
  logic         step_w;
  logic         term_w;
  logic         reload_w;
  logic         step_nz_w;
  logic         nib_nl_w;

  assign q_zero_w  = (q_w == '0);
  assign step_w    = nL & EN & BI & run_q;
  assign term_w    = step_w & q_zero_w;
  assign reload_w  = term_w & (mode_e'(MODE) == MODE_AUTO);
  assign step_nz_w = step_w & ~q_zero_w;
  // Auto-reload at terminal count reuses the slices' load path with current D.
  assign nib_nl_w  = nL & ~reload_w;

  for (genvar i = 0; i < STAGES; i++) begin : g_nib
    logic bi_w;
    logic bo_w;

    if (i == 0) begin : g_lsb
      assign bi_w = BI & run_q;
    end else begin : g_upper
      assign bi_w = g_nib[i-1].bo_w;
    end

    dcnt4 u_dcnt4 (
      .CK     (CK),
      .nRESET (nRESET),
      .D      (D[i*NIBBLE_W +: NIBBLE_W]),
      .nL     (nib_nl_w),
      .DEC    (step_nz_w & bi_w),
      .BI     (bi_w),
      .Q      (q_w[i*NIBBLE_W +: NIBBLE_W]),
      .BO     (bo_w)
    );
  end

  always_comb begin
    run_d = run_q;
    tc_d  = 1'b0;
    if (!nL) begin
      run_d = 1'b1;
    end else if (term_w) begin
      tc_d = 1'b1;
      if (mode_e'(MODE) == MODE_ONESHOT) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (!nRESET) begin
      run_q <= 1'b0;
      tc_q  <= 1'b0;
    end else begin
      run_q <= run_d;
      tc_q  <= tc_d;
    end
  end

  assign Q   = q_w;
  assign BO  = g_nib[STAGES-1].bo_w;
  assign TC  = tc_q;
  assign RUN = run_q;

endmodule

`default_nettype wire

// File: tb/tb_div_reload.sv
// tb_div_reload: directed vector table plus multi-cycle sequences for div_reload.
`default_nettype none

module tb_div_reload;

  logic        CK = 1'b0;
  logic        nRESET = 1'b0;
  logic [15:0] D = '0;
  logic        nL = 1'b1;
  logic        EN = 1'b0;
  logic        BI = 1'b1;
  logic        MODE = 1'b0;
  logic [15:0] Q;
  logic        BO, TC, RUN;

  int checks = 0;
  int failures = 0;

  div_reload #(.STAGES(4)) dut (
    .CK(CK), .nRESET(nRESET), .D(D), .nL(nL), .EN(EN), .BI(BI), .MODE(MODE),
    .Q(Q), .BO(BO), .TC(TC), .RUN(RUN)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic        nrst, nl, en, bi, mode;
    logic [15:0] d;
    logic [15:0] q;
    logic        tc, run, bo;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input logic nrst, nl, en, bi, mode, input logic [15:0] d,
                             input logic [15:0] q, input logic tc, run, bo);
    vec_t r;
    r.nrst = nrst; r.nl = nl; r.en = en; r.bi = bi; r.mode = mode; r.d = d;
    r.q = q; r.tc = tc; r.run = run; r.bo = bo;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked there too.
  task automatic apply(input logic nrst, nl, en, bi, mode, input logic [15:0] d);
    nRESET = nrst; nL = nl; EN = en; BI = bi; MODE = mode; D = d;
    @(posedge CK);
    #1;
  endtask

  initial begin
    int gap;
    int t;
    // nrst nl en bi mode d  |  q tc run bo
    // Reset, then auto-reload D=3: period 4
    vt.push_back(v(0, 1, 0, 1, 0, 16'h0003, 16'h0000, 0, 0, 0));
    vt.push_back(v(1, 0, 1, 1, 0, 16'h0003, 16'h0003, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h0003, 16'h0002, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h0003, 16'h0001, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h0003, 16'h0000, 0, 1, 1));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h0003, 16'h0003, 1, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h0003, 16'h0002, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h0003, 16'h0001, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h0003, 16'h0000, 0, 1, 1));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h0003, 16'h0003, 1, 1, 0));
    // One-shot D=2
    vt.push_back(v(1, 0, 1, 1, 1, 16'h0002, 16'h0002, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 1, 16'h0002, 16'h0001, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 1, 16'h0002, 16'h0000, 0, 1, 1));
    vt.push_back(v(1, 1, 1, 1, 1, 16'h0002, 16'h0000, 1, 0, 0));
    vt.push_back(v(1, 1, 1, 1, 1, 16'h0002, 16'h0000, 0, 0, 0));
    vt.push_back(v(1, 1, 1, 0, 1, 16'h0002, 16'h0000, 0, 0, 0));
    // Borrow across nibbles
    vt.push_back(v(1, 0, 1, 1, 0, 16'h0100, 16'h0100, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h0100, 16'h00FF, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h0100, 16'h00FE, 0, 1, 0));
    vt.push_back(v(1, 0, 1, 1, 0, 16'h1000, 16'h1000, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h1000, 16'h0FFF, 0, 1, 0));
    // Load wins over a pending terminal step (one-shot mode so a RUN clear would show)
    vt.push_back(v(1, 0, 1, 1, 1, 16'h0001, 16'h0001, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 1, 16'h0001, 16'h0000, 0, 1, 1));
    vt.push_back(v(1, 0, 1, 1, 1, 16'h0005, 16'h0005, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 1, 16'h0005, 16'h0004, 0, 1, 0));
    // BI / EN freeze at Q=7
    vt.push_back(v(1, 0, 1, 1, 0, 16'h0007, 16'h0007, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h0007, 16'h0006, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 0, 0, 16'h0007, 16'h0006, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 0, 0, 16'h0007, 16'h0006, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h0007, 16'h0005, 0, 1, 0));
    vt.push_back(v(1, 1, 0, 1, 0, 16'h0007, 16'h0005, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h0007, 16'h0004, 0, 1, 0));
    // D=0 auto-reload: TC on every step
    vt.push_back(v(1, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 1, 1));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h0000, 16'h0000, 1, 1, 1));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h0000, 16'h0000, 1, 1, 1));
    // Reset mid-count at Q=1
    vt.push_back(v(1, 0, 1, 1, 0, 16'h0002, 16'h0002, 0, 1, 0));
    vt.push_back(v(1, 1, 1, 1, 0, 16'h0002, 16'h0001, 0, 1, 0));
    vt.push_back(v(0, 1, 1, 1, 0, 16'h0002, 16'h0000, 0, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].nrst, vt[i].nl, vt[i].en, vt[i].bi, vt[i].mode, vt[i].d);
      chk($sformatf("row%0d Q", i),   {16'h0, Q}, {16'h0, vt[i].q});
      chk($sformatf("row%0d TC", i),  {31'h0, TC}, {31'h0, vt[i].tc});
      chk($sformatf("row%0d RUN", i), {31'h0, RUN}, {31'h0, vt[i].run});
      chk($sformatf("row%0d BO", i),  {31'h0, BO}, {31'h0, vt[i].bo});
    end

    // After reset: no TC and no counting without a load
    for (int i = 0; i < 8; i++) begin
      apply(1, 1, 1, 1, 0, 16'h0002);
      chk("post_reset TC", {31'h0, TC}, 32'h0);
      chk("post_reset Q", {16'h0, Q}, 32'h0);
    end

    // One-shot finish, then 10 held cycles with BI toggling
    apply(1, 0, 1, 1, 1, 16'h0002);
    for (int i = 0; i < 3; i++) apply(1, 1, 1, 1, 1, 16'h0002);
    chk("oneshot TC", {31'h0, TC}, 32'h1);
    chk("oneshot RUN", {31'h0, RUN}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      apply(1, 1, 1, 1'(i % 2), 1, 16'h0002);
      chk("oneshot hold Q", {16'h0, Q}, 32'h0);
      chk("oneshot hold TC", {31'h0, TC}, 32'h0);
      chk("oneshot hold BO", {31'h0, BO}, 32'h0);
    end

    // Auto-reload TC period with D=5 must be 6 cycles
    apply(1, 0, 1, 1, 0, 16'h0005);
    t = 0;
    do begin
      apply(1, 1, 1, 1, 0, 16'h0005);
      t++;
    end while (!TC && t < 20);
    chk("period first TC seen", {31'h0, TC}, 32'h1);
    gap = 0;
    do begin
      apply(1, 1, 1, 1, 0, 16'h0005);
      gap++;
    end while (!TC && gap < 20);
    chk("period gap", gap, 32'd6);

    // MODE switched mid-count takes effect at the terminal step
    apply(1, 0, 1, 1, 0, 16'h0003);
    apply(1, 1, 1, 1, 0, 16'h0003);
    chk("modechg Q", {16'h0, Q}, 32'h2);
    for (int i = 0; i < 3; i++) apply(1, 1, 1, 1, 1, 16'h0003);
    chk("modechg TC", {31'h0, TC}, 32'h1);
    chk("modechg RUN", {31'h0, RUN}, 32'h0);
    chk("modechg Q0", {16'h0, Q}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_reload.md
DIV_RELOAD -- requirements
Module: div_reload

Interface
REQ-001 SHALL have parameter STAGES, default 4, the number of cascaded 4-bit down-counter nibbles (counter width W = 4*STAGES).
REQ-002 SHALL have port CK, input, 1, the sole clock; all state updates on its rising edge.
REQ-003 SHALL have port nRESET, input, 1, a synchronous active-low reset, sampled on the CK rising edge.
REQ-004 SHALL have port D, input, W, the reload/preset value.
REQ-005 SHALL have port nL, input, 1, active-low immediate load of D.
REQ-006 SHALL have port EN, input, 1, the count enable.
REQ-007 SHALL have port BI, input, 1, the borrow-in for cascading; tie to 1 when standalone.
REQ-008 SHALL have port MODE, input, 1, where 0 = auto-reload and 1 = one-shot.
REQ-009 SHALL have port Q, output, W, the current count.
REQ-010 SHALL have port BO, output, 1, the combinational borrow-out, equal to BI & RUN & (Q == 0).
REQ-011 SHALL have port TC, output, 1, a registered one-cycle terminal-count pulse.
REQ-012 SHALL have port RUN, output, 1, high while the counter is armed.

Function
REQ-013 SHALL apply priority per edge as: reset, then load (nL=0), then count, then hold.
REQ-014 SHALL, on load, set Q<=D and RUN<=1, and drive TC to 0 on the next cycle, regardless of EN, BI or the current Q.
REQ-015 SHALL define a count step as an edge with nL=1, EN=1, BI=1 and RUN=1; all other non-load, non-reset edges hold Q and RUN and drive TC to 0.
REQ-016 SHALL, on a count step with Q != 0, set Q<=Q-1 with a full-width borrow across nibbles.
REQ-017 SHALL, on a count step with Q == 0 and MODE=0, set Q<=D (the D value sampled at that edge), keep RUN=1, and set TC<=1 for exactly one cycle.
REQ-018 SHALL, on a count step with Q == 0 and MODE=1, hold Q at 0, set RUN<=0, and set TC<=1 for exactly one cycle.
REQ-019 SHALL, in auto-reload mode with continuous steps, produce a TC period of D+1 cycles; D=0 SHALL make TC high on every step.
REQ-020 SHALL let load win when it coincides with a terminal step: no TC and no RUN clear.
REQ-021 SHALL, while RUN=0, ignore EN and BI, hold Q, and hold BO at 0.
REQ-022 SHALL freeze Q when BI or EN drops mid-count and resume from the held value without skipping.
REQ-023 SHALL have a TC that is never high on two consecutive cycles unless D=0 in auto-reload mode.
REQ-024 SHALL allow changing MODE mid-count, taking effect at the next terminal step.
REQ-025 SHALL make BO combinational from BI and the registered Q and RUN, so that units can be chained as BO to the next unit's BI.

Reset
REQ-026 SHALL, on an edge with nRESET=0, set Q<=0, RUN<=0 and TC<=0 regardless of all other inputs.
REQ-027 SHALL, on reset mid-count, abandon the count; no TC is emitted and counting restarts only after a load.
REQ-028 SHALL reach, at power-up before the first reset, the same register values as reset.

Structure
REQ-029 SHALL place the nibble width constant (4) and the MODE encodings (AUTO=0, ONESHOT=1) in the shared cell package.
REQ-030 SHALL instantiate STAGES copies of sub-module dcnt4, a 4-bit synchronous loadable down-counter with ports CK, nRESET, D[3:0], nL, DEC, BI, Q[3:0], BO; BO = BI & (Q==0).
REQ-031 SHALL chain each dcnt4 as follows: nibble i receives DEC = step & (all lower nibbles zero), and its BI comes from the lower nibble's BO.
REQ-032 SHALL implement the terminal and reload logic, TC and RUN in the div_reload top level.

Verification
REQ-033 SHALL cover: reset, then D=0x0003, nL pulse, MODE=0, EN=BI=1 -> Q sequence 3,2,1,0,3,2... with TC high one cycle after each Q=0 step, giving a period of 4.
REQ-034 SHALL cover: D=0x0002, MODE=1, load, then count -> Q 2,1,0, a single TC pulse, RUN=0, and Q held at 0 for 10 further cycles.
REQ-035 SHALL cover: D=0x0100, load, count -> Q goes 0x0100 to 0x00FF in one step, with correct borrow across nibbles.
REQ-036 SHALL cover: at Q=0 with a count step pending, assert nL with D=0x0005 -> Q=5, TC stays 0, RUN=1.
REQ-037 SHALL cover: at Q=7, toggle BI 1,0,0,1 -> Q goes 6, holds for two cycles, then 5; with RUN=0, BO=0 for any BI.
REQ-038 SHALL cover: nRESET=0 at Q=0x0001 while counting -> the next cycle shows Q=0, RUN=0, TC=0 and no subsequent TC without a load.
